// File: rtl/mpmc11_wr_burst_seq.sv
// Write burst sequencer for the mpmc11 MIG native app interface: issues len+1 write commands
// and streams len+1 data beats, letting data run at most MAX_LEAD beats ahead of commands.
`timescale 1ns/1ps
module mpmc11_wr_burst_seq #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ADDR_WIDTH = 29,
  parameter int unsigned ADDR_INC   = 8,
  parameter int unsigned MAX_LEAD   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [7:0]              req_len,
  input  logic [DATA_WIDTH-1:0]   src_data,
  input  logic [DATA_WIDTH/8-1:0] src_mask,
  input  logic                    src_valid,
  output logic                    src_ready,
  input  logic                    app_rdy,
  input  logic                    app_wdf_rdy,
  output logic                    app_en,
  output logic [2:0]              app_cmd,
  output logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_wdf_wren,
  output logic [DATA_WIDTH-1:0]   app_wdf_data,
  output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                    app_wdf_end,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e                state_q, state_d;
  logic [8:0]            cmd_cnt_q, cmd_cnt_d;
  logic [8:0]            dat_cnt_q, dat_cnt_d;
  logic [7:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  logic       in_burst, dok, cmd_fire, dat_fire;
  logic [8:0] len_p1;
  logic [9:0] lead_lim;

  // 9-bit counters so that len 255 (256 beats) can reach its terminal count.
  assign in_burst = (state_q == StBurst);
  assign len_p1   = {1'b0, len_q} + 9'd1;
  assign lead_lim = {1'b0, cmd_cnt_q} + 10'(MAX_LEAD);
  assign dok      = in_burst && (dat_cnt_q <= {1'b0, len_q}) && ({1'b0, dat_cnt_q} < lead_lim);

  assign req_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StDone);
  assign app_en       = in_burst && (cmd_cnt_q <= {1'b0, len_q});
  assign app_cmd      = 3'b000;
  assign app_addr     = addr_q;
  assign src_ready    = dok && app_wdf_rdy;
  assign app_wdf_wren = dok && src_valid;
  assign app_wdf_data = src_data;
  assign app_wdf_mask = src_mask;
  assign app_wdf_end  = app_wdf_wren && (dat_cnt_q == {1'b0, len_q});
  assign cmd_fire     = app_en && app_rdy;
  assign dat_fire     = app_wdf_wren && app_wdf_rdy;

  always_comb begin
    state_d   = state_q;
    cmd_cnt_d = cmd_cnt_q;
    dat_cnt_d = dat_cnt_q;
    len_d     = len_q;
    addr_d    = addr_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d    = req_addr;
          len_d     = req_len;
          cmd_cnt_d = '0;
          dat_cnt_d = '0;
          state_d   = StBurst;
        end
      end
      StBurst: begin
        if (cmd_fire) begin
          cmd_cnt_d = cmd_cnt_q + 9'd1;
          addr_d    = addr_q + ADDR_WIDTH'(ADDR_INC);
        end
        if (dat_fire) begin
          dat_cnt_d = dat_cnt_q + 9'd1;
        end
        // Next-state counts so the final acceptance cycle moves straight to StDone.
        if ((cmd_cnt_d == len_p1) && (dat_cnt_d == len_p1)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_cnt_q <= '0;
      dat_cnt_q <= '0;
      len_q     <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      cmd_cnt_q <= cmd_cnt_d;
      dat_cnt_q <= dat_cnt_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
    end
  end

endmodule

// File: tb/tb_mpmc11_wr_burst_seq.sv
// Self-checking bench for mpmc11_wr_burst_seq: scoreboard queues of expected commands and
// beats are filled when a burst is requested and drained by a monitor on accepted transfers.
`timescale 1ns/1ps
module tb_mpmc11_wr_burst_seq;
  localparam int unsigned DW = 128;
  localparam int unsigned AW = 29;
  localparam int unsigned MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_len;
  logic [DW-1:0] src_data;
  logic [MW-1:0] src_mask;
  logic          src_valid, src_ready;
  logic          app_rdy, app_wdf_rdy, app_en;
  logic [2:0]    app_cmd;
  logic [AW-1:0] app_addr;
  logic          app_wdf_wren, app_wdf_end;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          busy, done;

  mpmc11_wr_burst_seq #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ADDR_INC(8), .MAX_LEAD(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .src_data(src_data), .src_mask(src_mask), .src_valid(src_valid), .src_ready(src_ready),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_en(app_en), .app_cmd(app_cmd),
    .app_addr(app_addr), .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_end(app_wdf_end), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [MW-1:0] mask;
    logic          last;
  } beat_t;

  logic [AW-1:0] cmd_q[$];
  beat_t         beat_q[$];
  logic [AW-1:0] exp_a;
  beat_t         exp_b;
  int            checks = 0;
  int            errors = 0;

  logic [DW-1:0] gen_data[256];
  logic [MW-1:0] gen_mask[256];

  int n_cmd, n_beat, lead_beats, lead_viol, hold_viol, busy_cyc, done_cnt;
  int first_en_cyc, last_beat_cyc, done_cyc;

  // Scoreboard monitor: sampled mid-cycle, transfers land on the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (app_wdf_end && !app_wdf_wren) begin
        errors++;
        $display("FAIL end_without_wren got end=1 wren=0 want end=0");
      end
      if (app_en && app_rdy) begin
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd got addr=%h want none", app_addr);
        end else begin
          exp_a = cmd_q.pop_front();
          if (app_addr !== exp_a || app_cmd !== 3'b000) begin
            errors++;
            $display("FAIL cmd got addr=%h cmd=%b want addr=%h cmd=000", app_addr, app_cmd, exp_a);
          end
        end
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        checks++;
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got data=%h want none", app_wdf_data);
        end else begin
          exp_b = beat_q.pop_front();
          if (app_wdf_data !== exp_b.data || app_wdf_mask !== exp_b.mask ||
              app_wdf_end !== exp_b.last) begin
            errors++;
            $display("FAIL beat got data=%h mask=%h end=%b want data=%h mask=%h end=%b",
                     app_wdf_data, app_wdf_mask, app_wdf_end, exp_b.data, exp_b.mask, exp_b.last);
          end
        end
      end
    end
  end

  // mode 0: all ready; 1: app_rdy low for first 10 cycles; 2: app_wdf_rdy toggles.
  task automatic run_burst(input logic [AW-1:0] addr, input int len, input int mode,
                           input int abort_after);
    int cyc;
    int idx;
    logic stall_prev;
    logic [DW-1:0] prev_data;
    logic [MW-1:0] prev_mask;
    n_cmd = 0; n_beat = 0; lead_beats = 0; lead_viol = 0; hold_viol = 0;
    busy_cyc = 0; done_cnt = 0; first_en_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    for (int k = 0; k <= len; k++) begin
      gen_data[k] = {$urandom, $urandom, $urandom, $urandom};
      gen_mask[k] = MW'($urandom);
      cmd_q.push_back(AW'(32'(addr) + 32'(k) * 32'd8));
      beat_q.push_back(beat_t'{data: gen_data[k], mask: gen_mask[k], last: (k == len)});
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_len = 8'(len);
    @(posedge clk); #1;
    req_valid = 1'b0;
    idx = 0; stall_prev = 1'b0; prev_data = '0; prev_mask = '0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      app_rdy     = !(mode == 1 && cyc < 10);
      app_wdf_rdy = (mode == 2) ? (cyc[0] == 1'b0) : 1'b1;
      src_valid   = 1'b1;
      src_data    = gen_data[idx];
      src_mask    = gen_mask[idx];
      @(negedge clk);
      if (busy) busy_cyc++;
      if (app_en && first_en_cyc < 0) first_en_cyc = cyc;
      if (app_en && app_rdy) n_cmd++;
      if (stall_prev && (app_wdf_data !== prev_data || app_wdf_mask !== prev_mask)) hold_viol++;
      stall_prev = app_wdf_wren && !app_wdf_rdy;
      prev_data  = app_wdf_data;
      prev_mask  = app_wdf_mask;
      if (src_ready && src_valid) begin
        n_beat++;
        last_beat_cyc = cyc;
        if (mode == 1 && cyc < 10) lead_beats++;
        if (idx < len) idx++;
      end
      if (mode == 1 && cyc >= 2 && cyc < 10 && src_ready) lead_viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (abort_after > 0 && n_beat == abort_after) break;
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    if (abort_after == 0) begin
      checks++;
      if (done_cyc < 0) begin
        errors++;
        $display("FAIL burst_timeout got no done want done within 3000 cycles");
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, src_ready, done, busy, req_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_outputs got en=%b wren=%b end=%b srdy=%b done=%b busy=%b rrdy=%b want 0000001",
               app_en, app_wdf_wren, app_wdf_end, src_ready, done, busy, req_ready);
    end
  endtask

  task automatic test_single();
    run_burst(29'h100, 0, 0, 0);
    checks++;
    if (n_cmd !== 1 || n_beat !== 1) begin
      errors++;
      $display("FAIL single_counts got cmd=%0d beat=%0d want 1 1", n_cmd, n_beat);
    end
    checks++;
    if (first_en_cyc !== 0 || last_beat_cyc !== 0) begin
      errors++;
      $display("FAIL single_timing got en@%0d beat@%0d want 0 0", first_en_cyc, last_beat_cyc);
    end
    checks++;
    if (done_cyc !== 1 || done_cnt !== 1 || busy_cyc !== 2) begin
      errors++;
      $display("FAIL single_done got done@%0d n=%0d busy=%0d want 1 1 2", done_cyc, done_cnt, busy_cyc);
    end
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_idle got done=%b rrdy=%b want 0 1", done, req_ready);
    end
  endtask

  task automatic test_burst4();
    run_burst(29'h200, 3, 0, 0);
    checks++;
    if (n_cmd !== 4 || n_beat !== 4) begin
      errors++;
      $display("FAIL burst4_counts got cmd=%0d beat=%0d want 4 4", n_cmd, n_beat);
    end
    checks++;
    if (last_beat_cyc !== 3 || done_cyc !== 4 || busy_cyc !== 5) begin
      errors++;
      $display("FAIL burst4_timing got beat@%0d done@%0d busy=%0d want 3 4 5",
               last_beat_cyc, done_cyc, busy_cyc);
    end
    checks++;
    if (cmd_q.size() !== 0 || beat_q.size() !== 0) begin
      errors++;
      $display("FAIL burst4_drain got cmdq=%0d beatq=%0d want 0 0", cmd_q.size(), beat_q.size());
    end
  endtask

  task automatic test_lead_limit();
    run_burst(29'h1000, 7, 1, 0);
    checks++;
    if (lead_beats !== 2 || lead_viol !== 0) begin
      errors++;
      $display("FAIL lead_limit got beats=%0d srdy_hi=%0d want 2 0", lead_beats, lead_viol);
    end
    checks++;
    if (n_cmd !== 8 || n_beat !== 8 || cmd_q.size() !== 0 || beat_q.size() !== 0) begin
      errors++;
      $display("FAIL lead_complete got cmd=%0d beat=%0d want 8 8 and empty queues", n_cmd, n_beat);
    end
  endtask

  task automatic test_backpressure();
    run_burst(29'h2000, 7, 2, 0);
    checks++;
    if (hold_viol !== 0) begin
      errors++;
      $display("FAIL bp_hold got changes=%0d want 0", hold_viol);
    end
    checks++;
    if (n_beat !== 8 || n_cmd !== 8 || beat_q.size() !== 0 || cmd_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_complete got beat=%0d cmd=%0d want 8 8 and empty queues", n_beat, n_cmd);
    end
  endtask

  task automatic test_wrap_max();
    run_burst(29'h1FFF_FFF8, 255, 0, 0);
    checks++;
    if (n_cmd !== 256 || n_beat !== 256) begin
      errors++;
      $display("FAIL wrap_counts got cmd=%0d beat=%0d want 256 256", n_cmd, n_beat);
    end
    checks++;
    if (cmd_q.size() !== 0 || beat_q.size() !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL wrap_drain got cmdq=%0d beatq=%0d done=%0d want 0 0 1",
               cmd_q.size(), beat_q.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    run_burst(29'h300, 7, 0, 3);
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got busy=%b want 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({app_en, app_wdf_wren, app_wdf_end, src_ready, done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL mid_reset_drop got en=%b wren=%b end=%b srdy=%b done=%b busy=%b want 0",
               app_en, app_wdf_wren, app_wdf_end, src_ready, done, busy);
    end
    cmd_q.delete();
    beat_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_release got rrdy=%b busy=%b want 1 0", req_ready, busy);
    end
    run_burst(29'h400, 0, 0, 0);
    checks++;
    if (n_cmd !== 1 || n_beat !== 1 || done_cnt !== 1 || beat_q.size() !== 0) begin
      errors++;
      $display("FAIL mid_recover got cmd=%0d beat=%0d done=%0d want 1 1 1", n_cmd, n_beat, done_cnt);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    src_data = '0; src_mask = '0; src_valid = 1'b0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    test_reset();
    test_single();
    test_burst4();
    test_lead_limit();
    test_backpressure();
    test_wrap_max();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no finish want finish within 1ms");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mpmc11_wr_burst_seq.md
Name: mpmc11_wr_burst_seq

Overview:
- Sequences one write burst at a time onto the MIG native app interface for the mpmc11 controller.
- Accepts a burst request (address, length), then issues req_len+1 write commands on app_en/app_cmd/app_addr.
- Streams req_len+1 data beats from the port's write source onto app_wdf_*, asserting app_wdf_end on the final beat (beat count == burst length).
- Sits between the mpmc11 port arbiter and the MIG UI. Replaces ad-hoc end generation with a single command/data sequencer.

Parameters:
- DATA_WIDTH, 128, width of app_wdf_data; mask width is DATA_WIDTH/8.
- ADDR_WIDTH, 29, width of app_addr.
- ADDR_INC, 8, address increment per accepted command (BL8 on the DRAM column address).
- MAX_LEAD, 2, maximum number of data beats accepted ahead of accepted commands.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  high only in IDLE.
- req_addr  in  ADDR_WIDTH  start address.
- req_len  in  8  burst length minus one (0 = one beat).
- src_data  in  DATA_WIDTH  write beat data.
- src_mask  in  DATA_WIDTH/8  byte mask (1 = do not write).
- src_valid  in  1  beat valid.
- src_ready  out  1  beat accepted this cycle when src_valid is also high.
- app_rdy  in  1  MIG command accept.
- app_wdf_rdy  in  1  MIG write FIFO accept.
- app_en  out  1  command valid.
- app_cmd  out  3  always 3'b000 (write).
- app_addr  out  ADDR_WIDTH  command address.
- app_wdf_wren  out  1  data valid.
- app_wdf_data  out  DATA_WIDTH  data, passed through from src_data.
- app_wdf_mask  out  DATA_WIDTH/8  mask, passed through from src_mask.
- app_wdf_end  out  1  last beat of burst.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the burst is fully accepted.

Behaviour:
- Reset (asynchronous, any time, including mid-burst):
  - Forces state to IDLE and clears cmd_cnt, dat_cnt, len_r and addr_r to 0.
  - Outputs: app_en=0, app_wdf_wren=0, app_wdf_end=0, src_ready=0, done=0, busy=0, req_ready=1 after reset.
  - A partially issued burst is abandoned; no recovery is attempted.
- States: IDLE, BURST, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch addr_r=req_addr and len_r=req_len, clear both counters, go to BURST.
- BURST, command side:
  - app_en = (cmd_cnt <= len_r); app_addr = addr_r.
  - When app_en && app_rdy: cmd_cnt+1 and addr_r+ADDR_INC, wrapping modulo 2^ADDR_WIDTH.
  - app_en and app_addr stay stable until accepted.
- BURST, data side:
  - dok = (dat_cnt <= len_r) && (dat_cnt < cmd_cnt + MAX_LEAD).
  - src_ready = dok && app_wdf_rdy.
  - app_wdf_wren = dok && src_valid.
  - app_wdf_end = app_wdf_wren && (dat_cnt == len_r).
  - A beat transfers when app_wdf_wren && app_wdf_rdy; dat_cnt then increments.
- Counters are 9 bits so that len_r=255 terminates correctly.
- A command and a data beat may both be accepted in the same cycle; each counter updates independently. The lead check uses registered counts.
- BURST -> DONE when cmd_cnt == len_r+1 and dat_cnt == len_r+1. This includes the cycle where the final acceptances land: the next-state values are used, so there is no idle cycle.
- DONE: done=1 for exactly one cycle, then go to IDLE. req_ready=0 in DONE.
- Latency: the first app_en is asserted one cycle after req_valid is sampled in IDLE. Back-to-back bursts leave a minimum gap of 2 cycles (DONE, IDLE).
- app_cmd is constant 3'b000.

Test Plan:
- Single beat: req_len=0, req_addr=0x100, app_rdy=app_wdf_rdy=1, src_valid=1.
  - Required: one app_en at addr 0x100 and one wren with app_wdf_end=1 in the same cycle; done pulses 1 cycle later; busy high for 2 cycles.
- Burst of 4: req_len=3, addr 0x200, all ready.
  - Required: addresses 0x200, 0x208, 0x210, 0x218.
  - Required: app_wdf_end only on the 4th beat.
  - Required: done one cycle after the last beat.
- Data lead limit: req_len=7, app_rdy=0 for 10 cycles, app_wdf_rdy=1.
  - Required: exactly 2 beats accepted, then src_ready=0 until app_rdy rises.
  - Required: after that, all 8 commands and 8 beats complete, with end on beat 8.
- Backpressure: app_wdf_rdy toggles every cycle; src_valid is held.
  - Required: data and mask are held unchanged while app_wdf_rdy=0.
  - Required: no beat is lost or duplicated; dat_cnt reaches 8.
- Address wrap and max length: req_addr=2^29-8, req_len=255.
  - Required: the second command goes to address 0.
  - Required: 256 commands and 256 beats are issued; end occurs on beat 256.
- Reset mid-burst: assert rst after 3 beats of a req_len=7 burst.
  - Required: all outputs drop immediately; req_ready=1 after release.
  - Required: a new req_len=0 burst then completes normally.
